// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the flop-based FIFO.
// Holds default geometry and the occupancy counter width helper.
package fifo_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_BITS  = 16;

  // Occupancy must represent 0..depth inclusive.
  function automatic int cnt_w(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around modulo-depth pointer with increment enable.
// Ports: clk, rst_n (async low), inc, ptr.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int depth = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inc,
  output logic [$clog2(depth)-1:0] ptr
);

  localparam int PW = $clog2(depth);
  localparam logic [PW-1:0] LAST = PW'(depth - 1);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Explicit wrap so non-power-of-two depths work.
  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      if (ptr_q == LAST) ptr_d = '0;
      else               ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_flops_core.sv
// Single-clock flop FIFO, first-word fall-through read data.
// Ports: clk, rst (async low), Din/push, Dout/pop, full, pndng.
module fifo_flops_core
  import fifo_pkg::*;
#(
  parameter int depth = DEFAULT_DEPTH,
  parameter int bits  = DEFAULT_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] Din,
  input  logic            push,
  input  logic            pop,
  output logic [bits-1:0] Dout,
  output logic            full,
  output logic            pndng
);

  localparam int PW = $clog2(depth);
  localparam int CW = cnt_w(depth);
  localparam logic [CW-1:0] CMAX = CW'(depth);

  logic [bits-1:0] mem_q [depth];
  logic [bits-1:0] mem_d [depth];
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_d;
  logic [PW-1:0]   wr;
  logic [PW-1:0]   rd;
  logic            push_ok;
  logic            pop_ok;

  assign full  = (count == CMAX);
  assign pndng = (count != '0);

  // A pop frees the head slot in the same edge, so a
  // full FIFO can still take a push alongside it.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && pndng;

  fifo_ptr #(.depth(depth)) u_wr (
    .clk   (clk),
    .rst_n (rst),
    .inc   (push_ok),
    .ptr   (wr)
  );

  fifo_ptr #(.depth(depth)) u_rd (
    .clk   (clk),
    .rst_n (rst),
    .inc   (pop_ok),
    .ptr   (rd)
  );

  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr] = Din;
  end

  always_comb begin
    count_d = count;
    unique case (1'b1)
      push_ok && !pop_ok: count_d = count + 1'b1;
      pop_ok && !push_ok: count_d = count - 1'b1;
      default:            count_d = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
      count <= '0;
    end else begin
      mem_q <= mem_d;
      count <= count_d;
    end
  end

  assign Dout = pndng ? mem_q[rd] : '0;

endmodule

// File: tb/tb_fifo_flops_core.sv
// Self-checking bench for fifo_flops_core.
// Queue scoreboard of expected words, one task per scenario.
module tb_fifo_flops_core;

  logic        clk;
  logic        rst;
  logic [15:0] Din;
  logic        push;
  logic        pop;
  logic [15:0] Dout;
  logic        full;
  logic        pndng;

  int errors = 0;
  int checks = 0;

  logic [15:0] sb[$];

  fifo_flops_core #(.depth(16), .bits(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .Din   (Din),
    .push  (push),
    .pop   (pop),
    .Dout  (Dout),
    .full  (full),
    .pndng (pndng)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; records what the ideal FIFO accepts.
  task automatic drive(input bit p, input bit q,
                       input logic [15:0] d,
                       output logic [15:0] got,
                       output bit popped);
    popped = q && (sb.size() > 0);
    got = Dout;
    push = p;
    pop = q;
    Din = d;
    if (p && (sb.size() < 16 || popped)) sb.push_back(d);
    @(posedge clk);
    #1;
    push = 1'b0;
    pop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    push = 0; pop = 0; Din = '0; rst = 0;
    #2;
    checks++;
    if (dut.count !== 5'd0 || full !== 1'b0 ||
        pndng !== 1'b0 || Dout !== 16'h0) begin
      errors++;
      $display("FAIL reset: count=%0d full=%b pndng=%b Dout=%h want 0/0/0/0",
               dut.count, full, pndng, Dout);
    end
    do_reset();
  endtask

  task automatic test_fill_drain();
    logic [15:0] got, exp;
    bit pp;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(1, 0, 16'(k), got, pp);
      if (k == 14) begin
        checks++;
        if (full !== 1'b0) begin
          errors++;
          $display("FAIL fill_not_full: full=%b want 0", full);
        end
      end
      drive(0, 0, 16'hdead, got, pp);
    end
    checks++;
    if (full !== 1'b1 || dut.count !== 5'd16) begin
      errors++;
      $display("FAIL fill_full: full=%b count=%0d want 1/16",
               full, dut.count);
    end
    for (int k = 0; k < 16; k++) begin
      drive(0, 1, '0, got, pp);
      if (pp) begin
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL drain_data: got=%h want=%h", got, exp);
        end
      end
    end
    checks++;
    if (pndng !== 1'b0 || dut.count !== 5'd0) begin
      errors++;
      $display("FAIL drain_empty: pndng=%b count=%0d want 0/0",
               pndng, dut.count);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] got, exp;
    bit pp;
    do_reset();
    for (int k = 0; k < 40; k++) drive(1, 0, 16'(k), got, pp);
    checks++;
    if (dut.count !== 5'd16 || full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sat: count=%0d full=%b want 16/1",
               dut.count, full);
    end
    for (int k = 0; k < 17; k++) begin
      drive(0, 1, '0, got, pp);
      if (pp) begin
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL overflow_data: got=%h want=%h", got, exp);
        end
      end
    end
    checks++;
    if (pndng !== 1'b0 || Dout !== 16'h0) begin
      errors++;
      $display("FAIL overflow_empty: pndng=%b Dout=%h want 0/0",
               pndng, Dout);
    end
  endtask

  task automatic test_underflow();
    logic [15:0] got;
    bit pp;
    do_reset();
    for (int k = 0; k < 20; k++) drive(0, 1, '0, got, pp);
    checks++;
    if (dut.count !== 5'd0 || Dout !== 16'h0 || pndng !== 1'b0 ||
        dut.rd !== 4'd0 || dut.wr !== 4'd0) begin
      errors++;
      $display("FAIL underflow: count=%0d Dout=%h pndng=%b rd=%0d wr=%0d want 0",
               dut.count, Dout, pndng, dut.rd, dut.wr);
    end
  endtask

  task automatic test_simul();
    logic [15:0] got, exp;
    bit pp;
    do_reset();
    drive(1, 1, 16'h5a5a, got, pp);
    checks++;
    if (dut.count !== 5'd1 || Dout !== 16'h5a5a || pp) begin
      errors++;
      $display("FAIL simul_empty: count=%0d Dout=%h want 1/5a5a",
               dut.count, Dout);
    end
    for (int k = 1; k < 16; k++) drive(1, 0, 16'(16'h100 + k), got, pp);
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 16'(16'h200 + k), got, pp);
      if (pp) begin
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL simul_full_data: got=%h want=%h", got, exp);
        end
      end
      checks++;
      if (dut.count !== 5'd16 || full !== 1'b1) begin
        errors++;
        $display("FAIL simul_full_cnt: count=%0d full=%b want 16/1",
                 dut.count, full);
      end
    end
    for (int k = 0; k < 16; k++) begin
      drive(0, 1, '0, got, pp);
      if (pp) begin
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL simul_drain: got=%h want=%h", got, exp);
        end
      end
    end
  endtask

  task automatic test_interleave();
    logic [15:0] got, exp;
    bit pp;
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      drive(1, 0, 16'(16'h3000 + k), got, pp);
      checks++;
      if (dut.count !== 5'd1) begin
        errors++;
        $display("FAIL inter_cnt1: count=%0d want 1", dut.count);
      end
      drive(0, 1, '0, got, pp);
      exp = pp ? sb.pop_front() : 16'hffff;
      checks++;
      if (got !== exp || dut.count !== 5'd0) begin
        errors++;
        $display("FAIL inter_data: got=%h count=%0d want %h/0",
                 got, dut.count, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] got;
    bit pp;
    do_reset();
    for (int k = 0; k < 7; k++) drive(1, 0, 16'(16'h70 + k), got, pp);
    checks++;
    if (dut.count !== 5'd7) begin
      errors++;
      $display("FAIL areset_pre: count=%0d want 7", dut.count);
    end
    #1;
    rst = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (dut.count !== 5'd0 || pndng !== 1'b0 || Dout !== 16'h0) begin
      errors++;
      $display("FAIL areset_now: count=%0d pndng=%b Dout=%h want 0/0/0",
               dut.count, pndng, Dout);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 0, 16'habcd, got, pp);
    checks++;
    if (Dout !== 16'habcd || dut.count !== 5'd1) begin
      errors++;
      $display("FAIL areset_after: Dout=%h count=%0d want abcd/1",
               Dout, dut.count);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_simul();
    test_interleave();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_flops_core.md
# fifo_flops_core

Synchronous single-clock FIFO built from flip-flops (no RAM macro), with first-word-fall-through read data. It sits between a producer and a consumer that share one clock and use single-cycle push/pop strobes. Occupancy is exposed through `full` and `pndng` (data pending). Overflow and underflow are absorbed safely rather than corrupting state.

## Interface
- `depth`, default 16: number of entries; any value ≥ 2, not restricted to a power of two.
- `bits`, default 16: data word width.

Parameter order is `depth`, then `bits`.

- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, asynchronous and active-low.
- `Din`  in  `bits`: write data, sampled on a `clk` edge when `push` is accepted.
- `push`  in  1: write strobe, one entry per cycle it is high.
- `pop`  in  1: read strobe, removes the head entry per cycle it is high.
- `Dout`  out  `bits`: head entry, combinational from storage (first-word fall-through).
- `full`  out  1: `count == depth`.
- `pndng`  out  1: `count != 0`.

Internal signal `count`, width `$clog2(depth)+1`, holds the current occupancy. It must keep exactly this name so benches can probe it hierarchically.

## Operation
- Storage: `depth` × `bits` register array.
- Pointers: write pointer `wr`, read pointer `rd`. Each wraps from `depth-1` to 0.
- Push accepted = `push && (!full || pop)`:
  - writes `Din` to `mem[wr]`;
  - increments `wr`.
- Pop accepted = `pop && pndng`:
  - increments `rd`.
- `count` update:
  - +1 on push-only;
  - −1 on pop-only;
  - unchanged when both are accepted or neither is.
- Overflow (push while full, no pop): `Din` is dropped; memory, pointers and `count` are unchanged.
- Underflow (pop while empty): ignored; `count` never goes below 0.
- Push and pop together when empty: only the push is accepted, so `count` becomes 1.
- Push and pop together when full: both are accepted; `count` stays `depth` and the new word goes into the freed slot.
- `Dout = pndng ? mem[rd] : '0`.

## Timing
- Reset (`rst` low, asynchronous): `wr = rd = 0`, `count = 0`, all `mem` entries = 0. Resulting outputs: `full = 0`, `pndng = 0`, `Dout = 0`.
- A reset asserted mid-operation discards all contents immediately.
- Write latency: data pushed at edge N appears on `Dout` after edge N if the FIFO was empty (combinational read path).
- Flags and `count` update on the same edge as the accepted operation. There are no registered flag delays.
- Pop semantics: the consumer takes `Dout` in the cycle where it asserts `pop`; the next entry is presented after that edge.
- Strobes may stay high on consecutive cycles; each high cycle is one operation.

## Structure
- Package `fifo_pkg` holds `DEFAULT_DEPTH = 16`, `DEFAULT_BITS = 16`, and the helper for the count width (`$clog2(depth)+1`).
- One sub-module, `fifo_ptr`: a wrap-around modulo-`depth` pointer with increment enable and asynchronous active-low reset, instantiated for `wr` and `rd`.
- Flag and count logic live in the top level.

## Test plan
- Fill then drain: push 0..15 on alternate cycles → `full` rises after the 16th push with `count` = 16. Pop 16 times → `Dout` reads 0..15 in order, then `pndng = 0`.
- Overflow: after reset, push 40 words (0..39) with no pop → `count` saturates at 16 and `full = 1`. Subsequent popping yields 0..15 only.
- Underflow: after reset, pulse `pop` 20 times → `count` stays 0, `Dout = 0`, `pndng = 0`, and the pointers do not move.
- Simultaneous push/pop while empty with `Din = k` → `count` becomes 1. With the FIFO full, push+pop → `count` stays 16 and the order is preserved.
- Interleaved traffic: push k, then pop, for k = 0..16 → each pop returns k, and `count` toggles 1/0.
- Asynchronous reset asserted mid-fill (count = 7) → immediately `count = 0`, `pndng = 0`, `Dout = 0`. After reset releases, the next push is read back correctly.
